// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and sizing helpers for the convolution coprocessor divider.
package convolution_coprocessor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Iteration counter must hold values up to 2*data_width-1.
    function automatic int counter_width(input int data_width);
        return $clog2(2 * data_width);
    endfunction

endpackage

// File: rtl/convolution_coprocessor_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface convolution_coprocessor_div_if #(
    parameter int DATA_WIDTH = 22
);
    logic                      start;
    logic [2*DATA_WIDTH-1:0]   dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]     remainder;
    logic                      ovf;
    logic                      div_by_zero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, div_by_zero
    );

    // Divider side: consumes operands, produces results.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, div_by_zero
    );
endinterface

// File: rtl/convolution_coprocessor_div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module convolution_coprocessor_div_step #(
    parameter int DATA_WIDTH = 22
) (
    input  logic [DATA_WIDTH-1:0] prem,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] prem_next,
    output logic                  q_bit
);
    // The shifted partial remainder needs one extra bit; it is always < 2*divisor.
    logic [DATA_WIDTH:0] shifted;

    // Compare and subtract; the difference is < divisor, so DATA_WIDTH bits suffice.
    always_comb begin
        shifted   = {prem, bit_in};
        q_bit     = (shifted >= {1'b0, divisor});
        prem_next = q_bit ? (shifted[DATA_WIDTH-1:0] - divisor) : shifted[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/convolution_coprocessor_div.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
module convolution_coprocessor_div
    import convolution_coprocessor_pkg::*;
#(
    parameter int DATA_WIDTH = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    convolution_coprocessor_div_if.slave  bus
);
    localparam int QW = 2 * DATA_WIDTH;
    localparam int CW = counter_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

    div_state_e              state_reg;
    div_state_e              state_next;
    logic                    accept;
    logic [CW-1:0]           cnt_reg;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [QW-1:0]           shift_reg;
    logic [QW-1:0]           shift_next;
    logic [DATA_WIDTH-1:0]   divisor_reg;
    logic [DATA_WIDTH-1:0]   prem_reg;
    logic [DATA_WIDTH-1:0]   prem_next;
    logic                    q_bit;
    logic [QW-1:0]           quotient_reg;
    logic [DATA_WIDTH-1:0]   remainder_reg;
    logic                    ovf_reg;
    logic                    div_by_zero_reg;
    logic                    busy_reg;
    logic                    done_reg;

    convolution_coprocessor_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .prem      (prem_reg),
        .bit_in    (shift_reg[QW-1]),
        .divisor   (divisor_reg),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    assign shift_next = {shift_reg[QW-2:0], q_bit};

    // Next-state logic; a request is accepted in IDLE and in DONE (back-to-back).
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            shift_reg       <= '0;
            divisor_reg     <= '0;
            prem_reg        <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            ovf_reg         <= 1'b0;
            div_by_zero_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);

            if (accept) begin
                if (bus.divisor != '0) begin
                    shift_reg   <= bus.dividend;
                    divisor_reg <= bus.divisor;
                    prem_reg    <= '0;
                    cnt_reg     <= CNT_LAST;
                end else begin
                    // Division by zero resolves immediately with saturated results.
                    quotient_reg    <= '1;
                    remainder_reg   <= bus.dividend[DATA_WIDTH-1:0];
                    ovf_reg         <= 1'b1;
                    div_by_zero_reg <= 1'b1;
                end
            end else if (state_reg == RUN) begin
                shift_reg <= shift_next;
                prem_reg  <= prem_next;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end else begin
                    quotient_reg    <= shift_next;
                    remainder_reg   <= prem_next;
                    ovf_reg         <= |shift_next[QW-1:DATA_WIDTH];
                    div_by_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.ovf         = ovf_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_convolution_coprocessor_div.sv
// Directed bench for the restoring divider with a result scoreboard.
module tb_convolution_coprocessor_div;
    localparam int W  = 8;
    localparam int QW = 2 * W;

    typedef struct {
        logic [QW-1:0] q;
        logic [W-1:0]  r;
        logic          ovf;
        logic          dbz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    convolution_coprocessor_div_if #(.DATA_WIDTH(W)) bus ();

    convolution_coprocessor_div #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive a request for one cycle and push its arithmetic expectation.
    task automatic start_op(input logic [QW-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        if (dvs == 0) begin
            e.q = '1; e.r = dvd[W-1:0]; e.ovf = 1'b1; e.dbz = 1'b1;
        end else begin
            e.q = dvd / QW'(dvs);
            e.r = W'(dvd % QW'(dvs));
            e.ovf = (e.q > QW'(255));
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        $display("op %0d / %0d -> expect q=%0d r=%0d ovf=%0b dbz=%0b", dvd, dvs, e.q, e.r, e.ovf, e.dbz);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Called in the cycle after the accepting edge; ends in the done cycle.
    task automatic wait_result(input string tag);
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < QW; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (i == QW - 1) chk({tag, "_done_early"}, 64'(bus.done), 64'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(QW));
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_done: observed done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                $display("result q=%0d r=%0d ovf=%0b dbz=%0b", bus.quotient, bus.remainder, bus.ovf, bus.div_by_zero);
                chk("quotient", 64'(bus.quotient), 64'(e.q));
                chk("remainder", 64'(bus.remainder), 64'(e.r));
                chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1000/7 with full latency, then a back-to-back 50/6 from the done cycle.
        start_op(16'd1000, 8'd7);
        wait_result("t1");
        start_op(16'd50, 8'd6);
        chk("t6_hold_q", 64'(bus.quotient), 64'd142);
        chk("t6_hold_r", 64'(bus.remainder), 64'd6);
        wait_result("t6");
        @(negedge clk);

        // Overflowing quotients.
        start_op(16'd65535, 8'd255);
        wait_result("t2a");
        @(negedge clk);
        start_op(16'd65535, 8'd1);
        wait_result("t2b");
        @(negedge clk);

        // Divide by zero resolves in one cycle without ever raising busy.
        start_op(16'h1234, 8'd0);
        chk("t3_done", 64'(bus.done), 64'd1);
        chk("t3_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("t3_busy_after", 64'(bus.busy), 64'd0);

        // A request during busy must be ignored.
        start_op(16'd100, 8'd3);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 8'd9;
        @(negedge clk);
        bus.start    = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_done_early", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("t4_done", 64'(bus.done), 64'd1);
        repeat (20) @(negedge clk);
        chk("t4_no_second_done", 64'(bus.done), 64'd0);

        // Zero dividend still takes the full latency.
        start_op(16'd0, 8'd5);
        wait_result("t0");
        @(negedge clk);

        // Reset in the middle of a run discards it.
        start_op(16'd200, 8'd10);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_done", 64'(bus.done), 64'd0);
        chk("t5_quotient", 64'(bus.quotient), 64'd0);
        chk("t5_remainder", 64'(bus.remainder), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        start_op(16'd200, 8'd10);
        wait_result("t5b");
        @(negedge clk);

        // A few random operand pairs.
        for (int n = 0; n < 4; n++) begin
            start_op(QW'($urandom_range(0, 65535)), W'($urandom_range(1, 255)));
            wait_result("rnd");
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/convolution_coprocessor_div.md
Name: convolution_coprocessor_div

Overview:
Sequential unsigned restoring divider for the convolution coprocessor. It is the inverse of the coprocessor multiplier: it takes a 2*DATA_WIDTH product-width dividend and a DATA_WIDTH divisor, and returns quotient and remainder. Used to normalise or scale accumulated convolution sums back to sample width. It produces one quotient bit per clock under a start/busy/done handshake.

Parameters:
DATA_WIDTH, 22, divisor and remainder width; dividend and quotient are 2*DATA_WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request; sampled only when not busy
dividend  input  2*DATA_WIDTH  unsigned dividend, captured on accepted start
divisor  input  DATA_WIDTH  unsigned divisor, captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when results are valid
quotient  output  2*DATA_WIDTH  unsigned quotient, held until next done
remainder  output  DATA_WIDTH  unsigned remainder, held until next done
ovf  output  1  quotient does not fit in DATA_WIDTH bits (quotient[2W-1:W] != 0)
div_by_zero  output  1  captured divisor was 0

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; busy=0, done=0, quotient=0, remainder=0, ovf=0, div_by_zero=0; iteration counter=0. Reset has priority over everything, including mid-RUN; the in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 at edge k captures operands.
  - divisor!=0 -> RUN, counter=2*DATA_WIDTH-1, partial remainder=0.
  - divisor==0 -> DONE directly: quotient=all ones, remainder=dividend[DATA_WIDTH-1:0], div_by_zero=1, ovf=1. done is high in the cycle after edge k (latency 1).
- RUN: each edge shifts the next dividend bit (MSB first) into the partial remainder (DATA_WIDTH+1 bits, no overflow possible).
  - If partial remainder >= divisor: subtract, and the quotient bit is 1.
  - Otherwise: restore, and the quotient bit is 0.
  - Counter decrements each edge. The iteration at counter==0 is the last; at that edge the FSM goes to DONE, and quotient, remainder, ovf and div_by_zero=0 are loaded.
- busy=1 throughout RUN. The cycle after the accepting edge has busy=1, done=0.
- Latency: start sampled at edge k -> done=1 in the cycle after edge k+2*DATA_WIDTH.
- DONE: done=1 for exactly one cycle.
  - start=0 -> IDLE.
  - start=1 -> accepted as a new operation (back-to-back, no idle bubble).
- start while busy: ignored, operands not captured, no effect on the result.
- quotient, remainder, ovf and div_by_zero keep their last values through IDLE and the next RUN. They change only at the edge that enters DONE, or on reset.
- Exactness: quotient*divisor+remainder==dividend and remainder<divisor for every nonzero divisor.
- dividend=0 -> quotient=0, remainder=0, full 2*DATA_WIDTH latency. No early termination.

Decomposition:
- Shared package convolution_coprocessor_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparam function for counter width, $clog2(2*DATA_WIDTH)
- One combinational sub-module is natural: convolution_coprocessor_div_step. It takes the partial remainder, incoming bit and divisor, and returns the next partial remainder and quotient bit.
- FSM, counter and result registers stay in the top.

Test Plan:
1. DATA_WIDTH=8, dividend=1000, divisor=7, start pulse at edge k -> done at cycle after edge k+16; quotient=142, remainder=6, ovf=0, div_by_zero=0; busy high for 16 cycles.
2. dividend=65535, divisor=255 -> quotient=257, remainder=0, ovf=1. Also dividend=65535, divisor=1 -> quotient=65535, remainder=0, ovf=1.
3. divisor=0, dividend=0x1234 -> done in the cycle after the accepting edge; div_by_zero=1, ovf=1, quotient=0xFFFF, remainder=0x34; busy never high.
4. Start 100/3, then pulse start with 9/9 at busy cycle 5 -> second request ignored; single done with quotient=33, remainder=1.
5. rst_n=0 at RUN cycle 8 of 200/10 -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse appears later. A new start of 200/10 then gives quotient=20, remainder=0.
6. start held high in the DONE cycle with 50/6 after a 1000/7 result -> done pulses 16 cycles later with quotient=8, remainder=2. Outputs keep 142/6 until that pulse.
